atm_keypad_frontend: RTL and testbench
======================================

Name: atm_keypad_frontend

Overview:
- Customer-side front end for the ATM controller.
- Assembles keypad strobes into account number, PIN, menu option, destination account and amount.
- Issues each completed request to the ATM controller over a valid/ready handshake, then captures the controller's response (error, balance) for display.
- Sits between the keypad scanner and the ATM controller, driving the controller's request inputs and consuming its outputs.

Parameters:
- IDLE_TIMEOUT, 1000, inactivity cycles in any entry state before automatic cancel.
- RESP_TIMEOUT, 64, cycles in WAIT_RESP before the request is abandoned.
- ACC_DIGITS, 4, maximum digits accepted for account fields.
- AMT_DIGITS, 4, maximum digits accepted for the amount field.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  one-cycle strobe, key_code valid.
- key_code  in  4  0-9 digit; 4'hA ENTER; 4'hB CLEAR; 4'hC CANCEL; others ignored.
- accNumber  out  12  assembled account number.
- pin  out  4  assembled PIN.
- destinationAcc  out  12  assembled destination account.
- amount  out  11  assembled amount.
- menuOption  out  3  request opcode: 0 login, 3 balance, 4 withdraw, 5 withdraw+show, 6 transfer.
- req_valid  out  1  request pending.
- req_ready  in  1  controller accepts the request.
- resp_valid  in  1  controller response strobe.
- resp_error  in  1  controller rejected the request.
- resp_balance  in  11  balance reported by the controller.
- exit  out  1  one-cycle logout pulse to the controller.
- disp_balance  out  11  last captured balance.
- disp_error  out  1  last request failed, or entry was rejected.
- state_o  out  4  current FSM state, for the display.

Behaviour:
- Reset (async on rst_n low): state IDLE; all outputs 0; digit counters, accumulators and timers cleared.
- States:
  - IDLE=0
  - ACC=1
  - PIN=2
  - LOGIN=3
  - MENU=4
  - DEST=5
  - AMT=6
  - ISSUE=7
  - WAIT_RESP=8
- Digit entry in ACC, PIN, DEST and AMT:
  - acc = acc*10 + digit, using a 14-bit accumulator.
  - Digits beyond the field's maximum count are ignored; PIN maximum is 1 digit.
  - CLEAR zeroes the current field and its digit counter.
- ENTER validation; on rejection, pulse disp_error for 1 cycle, clear the field, and stay in the state:
  - Zero digits entered: reject.
  - Account value > 4095: reject.
  - Amount value > 2047: reject.
- Transitions:
  - IDLE, any digit: go to ACC, with that digit captured.
  - ACC, ENTER accepted: go to PIN.
  - PIN, ENTER accepted: set menuOption=0, go to LOGIN.
  - LOGIN: req_valid=1.
  - MENU, digit: latches a candidate option; the last digit wins.
  - MENU, ENTER with 3: go to ISSUE.
  - MENU, ENTER with 4 or 5: go to AMT.
  - MENU, ENTER with 6: go to DEST.
  - MENU, ENTER with 0: exit pulse, clear everything, go to IDLE.
  - MENU, ENTER with any other value: rejected.
  - DEST, ENTER accepted: go to AMT.
  - AMT, ENTER accepted: go to ISSUE.
- Handshake:
  - req_valid rises the cycle after the accepted ENTER.
  - Request outputs are stable while req_valid=1.
  - The transfer completes on the cycle where req_valid and req_ready are both high.
  - Then req_valid=0 and the FSM enters WAIT_RESP.
  - resp_valid is ignored outside WAIT_RESP.
- Response handling:
  - In WAIT_RESP, resp_valid captures disp_error=resp_error and, when resp_error=0, disp_balance=resp_balance.
  - Login response: error=0 goes to MENU; error=1 clears accNumber and pin and goes to ACC.
  - Other responses go to MENU; amount and destinationAcc are cleared.
- CANCEL:
  - In IDLE, ACC, PIN, MENU, DEST or AMT: exit pulse, all fields cleared, go to IDLE.
  - In LOGIN, ISSUE or WAIT_RESP: ignored; the request must complete.
- Timeouts:
  - The idle timer resets on every key_valid and on every state change.
  - At IDLE_TIMEOUT in an entry state other than IDLE, behave as CANCEL.
  - RESP_TIMEOUT in WAIT_RESP: disp_error=1, then go to MENU, or to ACC if the request was a login.
- Keys arriving in LOGIN, ISSUE or WAIT_RESP are dropped, apart from CANCEL being ignored.
- A key_valid in the same cycle as a state change is processed in the new state only from the next strobe.

Test Plan:
- Keys 2,7,4,9,ENTER,0,ENTER with req_ready=1 -> accNumber=2749, pin=0, menuOption=0, one-cycle req handshake; resp_valid with error=0 -> state_o=4.
- Login with resp_error=1 -> state_o=1, accNumber=0, disp_error=1.
- From MENU: 4,ENTER,2,0,0,ENTER -> menuOption=4, amount=200; resp_balance=300, error=0 -> disp_balance=300, state_o=4.
- Amount 3,0,0,0,ENTER -> disp_error pulse, amount=0, state stays AMT; account 9,9,9,9,ENTER -> rejected likewise.
- req_ready held low for 10 cycles in ISSUE with CANCEL pressed -> req_valid stays 1, no exit; after req_ready, no response for 64 cycles -> disp_error=1, state_o=4.
- Menu 0,ENTER -> exit high exactly one cycle, state_o=0; rst_n low mid-WAIT_RESP -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/atm_keypad_frontend.sv
// Customer-side keypad front end for the ATM controller. It assembles the keypad fields,
// issues each request over a valid/ready handshake and captures the response for display.
module atm_keypad_frontend #(
  parameter int IDLE_TIMEOUT = 1000,
  parameter int RESP_TIMEOUT = 64,
  parameter int ACC_DIGITS   = 4,
  parameter int AMT_DIGITS   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [11:0] accNumber,
  output logic [3:0]  pin,
  output logic [11:0] destinationAcc,
  output logic [10:0] amount,
  output logic [2:0]  menuOption,
  output logic        req_valid,
  input  logic        req_ready,
  input  logic        resp_valid,
  input  logic        resp_error,
  input  logic [10:0] resp_balance,
  output logic        exit,
  output logic [10:0] disp_balance,
  output logic        disp_error,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_ACC = 4'd1, S_PIN = 4'd2, S_LOGIN = 4'd3, S_MENU = 4'd4,
    S_DEST = 4'd5, S_AMT = 4'd6, S_ISSUE = 4'd7, S_WAIT = 4'd8
  } state_t;

  localparam int TMAX = (IDLE_TIMEOUT > RESP_TIMEOUT) ? IDLE_TIMEOUT : RESP_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_TIMEOUT - 1);
  localparam logic [TW-1:0] RESP_LAST = TW'(RESP_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_SAT = TW'(TMAX);

  state_t          state_q, state_d;
  logic [13:0]     acc_q, acc_shifted, limit;
  logic [3:0]      cnt_q, max_digits;
  logic [TW-1:0]   timer_q;
  logic            resp_err_q, reject_q;
  logic            is_digit, is_enter, is_clear, is_cancel;
  logic            entry_state, is_login, enter_ok, do_logout, idle_expire, resp_expire;

  // Key decode and per-field entry rules.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    is_digit    = key_valid && (key_code <= 4'd9);
    is_enter    = key_valid && (key_code == 4'hA);
    is_clear    = key_valid && (key_code == 4'hB);
    is_cancel   = key_valid && (key_code == 4'hC);
    entry_state = state_q inside {S_ACC, S_PIN, S_MENU, S_DEST, S_AMT};
    is_login    = (menuOption == 3'd0);
    acc_shifted = acc_q * 14'd10 + {10'd0, key_code};
    max_digits  = 4'd0;
    limit       = 14'd0;
    case (state_q)
      S_ACC, S_DEST: begin max_digits = 4'(ACC_DIGITS); limit = 14'd4095; end
      S_PIN:         begin max_digits = 4'd1;           limit = 14'd9;    end
      S_AMT:         begin max_digits = 4'(AMT_DIGITS); limit = 14'd2047; end
      default:       ;
    endcase
    if (state_q == S_MENU)
      enter_ok = is_enter && (cnt_q != 4'd0) && (acc_q inside {14'd0, [14'd3:14'd6]});
    else
      enter_ok = is_enter && (cnt_q != 4'd0) && (acc_q <= limit);
    idle_expire = entry_state && !key_valid && (timer_q == IDLE_LAST);
    resp_expire = (state_q == S_WAIT) && !resp_valid && (timer_q == RESP_LAST);
    // Menu option 0 is a voluntary logout and shares the cancel path.
    do_logout   = (is_cancel && (entry_state || state_q == S_IDLE)) || idle_expire ||
                  (state_q == S_MENU && enter_ok && acc_q == 14'd0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (do_logout) state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE: if (is_digit) state_d = S_ACC;
        S_ACC:  if (enter_ok) state_d = S_PIN;
        S_PIN:  if (enter_ok) state_d = S_LOGIN;
        S_MENU: if (enter_ok) begin
          case (acc_q[2:0])
            3'd3:       state_d = S_ISSUE;
            3'd4, 3'd5: state_d = S_AMT;
            3'd6:       state_d = S_DEST;
            default:    ;
          endcase
        end
        S_DEST: if (enter_ok) state_d = S_AMT;
        S_AMT:  if (enter_ok) state_d = S_ISSUE;
        S_LOGIN, S_ISSUE: if (req_valid && req_ready) state_d = S_WAIT;
        S_WAIT: if (resp_valid)       state_d = (is_login && resp_error) ? S_ACC : S_MENU;
                else if (resp_expire) state_d = is_login ? S_ACC : S_MENU;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    state_o    = state_q;
    disp_error = resp_err_q | reject_q;
  end

  // Field assembly, request/response registers and the shared inactivity/response timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0; cnt_q <= '0; timer_q <= '0;
      accNumber <= '0; pin <= '0; destinationAcc <= '0; amount <= '0; menuOption <= '0;
      req_valid <= 1'b0; exit <= 1'b0; disp_balance <= '0; resp_err_q <= 1'b0; reject_q <= 1'b0;
    end else begin
      exit     <= 1'b0;
      reject_q <= 1'b0;
      if ((state_d != state_q) || (key_valid && entry_state)) timer_q <= '0;
      else if (timer_q != TIMER_SAT)                          timer_q <= timer_q + 1'b1;

      if (do_logout) begin
        exit <= 1'b1;
        acc_q <= '0; cnt_q <= '0;
        accNumber <= '0; pin <= '0; destinationAcc <= '0; amount <= '0; menuOption <= '0;
        req_valid <= 1'b0; disp_balance <= '0; resp_err_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (is_digit) begin acc_q <= {10'd0, key_code}; cnt_q <= 4'd1; end
          S_ACC, S_PIN, S_MENU, S_DEST, S_AMT: begin
            if (is_clear || is_enter) begin acc_q <= '0; cnt_q <= '0; end
            if (is_enter && !enter_ok) reject_q <= 1'b1;
            if (is_clear || (is_enter && !enter_ok)) begin
              case (state_q)
                S_ACC:   accNumber <= '0;
                S_PIN:   pin <= '0;
                S_DEST:  destinationAcc <= '0;
                S_AMT:   amount <= '0;
                default: ;
              endcase
            end
            if (is_digit) begin
              if (state_q == S_MENU) begin acc_q <= {10'd0, key_code}; cnt_q <= 4'd1; end
              else if (cnt_q < max_digits) begin acc_q <= acc_shifted; cnt_q <= cnt_q + 4'd1; end
            end
            if (enter_ok) begin
              case (state_q)
                S_ACC:  accNumber <= acc_q[11:0];
                S_PIN:  begin pin <= acc_q[3:0]; menuOption <= 3'd0; req_valid <= 1'b1; end
                S_MENU: begin
                  menuOption <= acc_q[2:0];
                  if (acc_q == 14'd3) req_valid <= 1'b1;
                end
                S_DEST: destinationAcc <= acc_q[11:0];
                S_AMT:  begin amount <= acc_q[10:0]; req_valid <= 1'b1; end
                default: ;
              endcase
            end
          end
          S_LOGIN, S_ISSUE: if (req_valid && req_ready) req_valid <= 1'b0;
          S_WAIT: if (resp_valid || resp_expire) begin
            resp_err_q <= resp_valid ? resp_error : 1'b1;
            if (resp_valid && !resp_error) disp_balance <= resp_balance;
            if (!is_login) begin amount <= '0; destinationAcc <= '0; end
            else if (!resp_valid || resp_error) begin accNumber <= '0; pin <= '0; end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Directed and randomized bench for atm_keypad_frontend; expectations come from a
// field-level model of keypad sessions built from digit lists and plain arithmetic.
module tb_atm_keypad_frontend;
  localparam logic [3:0] K_ENTER = 4'hA, K_CLEAR = 4'hB, K_CANCEL = 4'hC;
  localparam int ST_IDLE = 0, ST_ACC = 1, ST_PIN = 2, ST_LOGIN = 3, ST_MENU = 4;
  localparam int ST_DEST = 5, ST_AMT = 6, ST_ISSUE = 7, ST_WAIT = 8;

  logic        clk = 1'b0, rst_n = 1'b0, key_valid = 1'b0;
  logic [3:0]  key_code = '0;
  logic        req_ready = 1'b0, resp_valid = 1'b0, resp_error = 1'b0;
  logic [10:0] resp_balance = '0;
  logic [11:0] accNumber, destinationAcc;
  logic [3:0]  pin, state_o;
  logic [10:0] amount, disp_balance;
  logic [2:0]  menuOption;
  logic        req_valid, exit, disp_error;

  atm_keypad_frontend dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .accNumber(accNumber), .pin(pin), .destinationAcc(destinationAcc), .amount(amount),
    .menuOption(menuOption), .req_valid(req_valid), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_error(resp_error), .resp_balance(resp_balance),
    .exit(exit), .disp_balance(disp_balance), .disp_error(disp_error), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0, exit_seen = 0, hs_seen = 0;
  int exp_bal = 0, exp_err = 0;

  always @(posedge clk) begin
    #1;
    if (exit === 1'b1) exit_seen++;
  end
  always @(posedge clk) if (req_valid && req_ready) hs_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t required earlier end", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic press(input logic [3:0] k);
    key_code = k; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; key_code = '0;
  endtask

  task automatic respond(input logic err, input logic [10:0] bal);
    resp_valid = 1'b1; resp_error = err; resp_balance = bal;
    @(negedge clk);
    resp_valid = 1'b0; resp_error = 1'b0; resp_balance = '0;
  endtask

  // Wait (bounded) for a pending request, accept it for one cycle, confirm WAIT_RESP.
  task automatic complete_req(input string tag);
    int t = 0;
    while (req_valid !== 1'b1 && t < 8) begin @(negedge clk); t++; end
    check({tag, " req_valid"}, req_valid, 1);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    check({tag, " wait_resp"}, state_o, ST_WAIT);
    check({tag, " req_valid drop"}, req_valid, 0);
  endtask

  // Reference response model: error level persists; balance updates only on success.
  task automatic respond_model(input logic err, input logic [10:0] bal);
    respond(err, bal);
    exp_err = err;
    if (!err) exp_bal = bal;
  endtask

  task automatic do_login(input int acc, input int pn, input logic err, input logic [10:0] bal);
    press(4'(acc / 1000)); press(4'((acc / 100) % 10)); press(4'((acc / 10) % 10)); press(4'(acc % 10));
    press(K_ENTER);
    check("login acc accepted", state_o, ST_PIN);
    press(4'(pn));
    press(K_ENTER);
    check("login state", state_o, ST_LOGIN);
    check("login accNumber", accNumber, acc);
    check("login pin", pin, pn);
    check("login menuOption", menuOption, 0);
    complete_req("login");
    respond_model(err, bal);
    check("login result state", state_o, err ? ST_ACC : ST_MENU);
    check("login disp_error", disp_error, exp_err);
    check("login disp_balance", disp_balance, exp_bal);
  endtask

  // Random field entry: digits with occasional CLEAR, then ENTER. Model keeps the
  // digit list, folds the first maxd digits to a number and applies the field limit.
  task automatic enter_field(input int maxd, input int limit, output bit ok, output int val);
    int q[$];
    int n = $urandom_range(0, 6);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        press(K_CLEAR); q.delete();
      end else begin
        int d = $urandom_range(0, 9);
        press(4'(d)); q.push_back(d);
      end
    end
    press(K_ENTER);
    val = 0;
    for (int i = 0; i < q.size() && i < maxd; i++) val = val * 10 + q[i];
    ok = (q.size() > 0) && (val <= limit);
  endtask

  initial begin
    int hs0, ex0, cyc, opt, val;
    bit ok;
    logic err;
    logic [10:0] bal;

    // Reset state
    #7;
    check("rst state", state_o, ST_IDLE);
    check("rst accNumber", accNumber, 0);
    check("rst pin", pin, 0);
    check("rst dest", destinationAcc, 0);
    check("rst amount", amount, 0);
    check("rst menuOption", menuOption, 0);
    check("rst req_valid", req_valid, 0);
    check("rst exit", exit, 0);
    check("rst disp_balance", disp_balance, 0);
    check("rst disp_error", disp_error, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Login 2749 / 0 with req_ready held high
    req_ready = 1'b1;
    press(4'd2);
    check("first digit enters ACC", state_o, ST_ACC);
    press(4'd7); press(4'd4); press(4'd9); press(K_ENTER);
    check("acc accepted", state_o, ST_PIN);
    check("accNumber 2749", accNumber, 2749);
    press(4'd0);
    hs0 = hs_seen;
    press(K_ENTER);
    check("login req_valid rises", req_valid, 1);
    check("login state", state_o, ST_LOGIN);
    check("pin 0", pin, 0);
    check("menuOption 0", menuOption, 0);
    @(negedge clk);
    check("login in WAIT_RESP", state_o, ST_WAIT);
    check("req_valid after transfer", req_valid, 0);
    req_ready = 1'b0;
    @(negedge clk);
    check("one handshake", hs_seen - hs0, 1);
    respond_model(1'b0, 11'd500);
    check("login ok -> MENU", state_o, ST_MENU);
    check("login balance", disp_balance, 500);

    // Withdraw 200
    press(4'd4); press(K_ENTER);
    check("withdraw -> AMT", state_o, ST_AMT);
    press(4'd2); press(4'd0); press(4'd0); press(K_ENTER);
    check("amount accepted", state_o, ST_ISSUE);
    check("amount 200", amount, 200);
    check("menuOption 4", menuOption, 4);
    complete_req("withdraw");
    respond_model(1'b0, 11'd300);
    check("withdraw balance", disp_balance, 300);
    check("withdraw -> MENU", state_o, ST_MENU);
    check("amount cleared", amount, 0);

    // Amount > 2047 rejected, then CANCEL from AMT
    press(4'd4); press(K_ENTER);
    press(4'd3); press(4'd0); press(4'd0); press(4'd0); press(K_ENTER);
    check("amt reject pulse", disp_error, 1);
    check("amt reject stays", state_o, ST_AMT);
    check("amt reject amount", amount, 0);
    @(negedge clk);
    check("amt reject pulse ends", disp_error, 0);
    press(K_CANCEL);
    check("cancel exit", exit, 1);
    check("cancel -> IDLE", state_o, ST_IDLE);
    @(negedge clk);
    check("cancel exit one cycle", exit, 0);
    exp_bal = 0; exp_err = 0;
    check("cancel clears balance", disp_balance, 0);

    // Account 9999 rejected; CLEAR mid-entry; login failure
    press(4'd9); press(4'd9); press(4'd9); press(4'd9); press(K_ENTER);
    check("acc reject pulse", disp_error, 1);
    check("acc reject stays", state_o, ST_ACC);
    check("acc reject value", accNumber, 0);
    press(4'd1); press(4'd2); press(K_CLEAR); press(4'd5); press(K_ENTER);
    check("clear then 5", accNumber, 5);
    press(4'd3); press(K_ENTER);
    complete_req("bad login");
    respond_model(1'b1, 11'd999);
    check("login fail -> ACC", state_o, ST_ACC);
    check("login fail accNumber", accNumber, 0);
    check("login fail pin", pin, 0);
    check("login fail disp_error", disp_error, 1);
    check("login fail balance kept", disp_balance, 0);
    do_login(1234, 2, 1'b0, 11'd1500);

    // Transfer; CANCEL ignored in ISSUE; response timeout
    press(4'd6); press(K_ENTER);
    check("transfer -> DEST", state_o, ST_DEST);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5); press(K_ENTER);
    check("fifth digit ignored", destinationAcc, 1234);
    press(4'd5); press(4'd0); press(K_ENTER);
    check("transfer ISSUE", state_o, ST_ISSUE);
    ex0 = exit_seen;
    press(K_CANCEL);
    for (int i = 0; i < 9; i++) @(negedge clk);
    check("issue req_valid held", req_valid, 1);
    check("issue cancel ignored", state_o, ST_ISSUE);
    check("issue no exit", exit_seen - ex0, 0);
    check("issue dest stable", destinationAcc, 1234);
    check("issue amount stable", amount, 50);
    check("issue menuOption", menuOption, 6);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    check("transfer WAIT", state_o, ST_WAIT);
    cyc = 0;
    while (state_o == 4'(ST_WAIT) && cyc < 200) begin @(negedge clk); cyc++; end
    check("resp timeout cycles", cyc, 64);
    check("resp timeout -> MENU", state_o, ST_MENU);
    check("resp timeout error", disp_error, 1);
    check("resp timeout dest cleared", destinationAcc, 0);
    exp_err = 1;
    respond(1'b0, 11'd77);
    check("resp ignored balance", disp_balance, exp_bal);
    check("resp ignored error", disp_error, exp_err);

    // Idle timeout from MENU after a candidate digit
    press(4'd7);
    ex0 = exit_seen;
    cyc = 0;
    while (state_o != 4'(ST_IDLE) && cyc < 1100) begin @(negedge clk); cyc++; end
    check("idle timeout cycles", cyc, 1000);
    check("idle timeout exit", exit_seen - ex0, 1);
    exp_bal = 0; exp_err = 0;

    // Randomized sessions from MENU
    do_login($urandom_range(1000, 4095), $urandom_range(0, 9), 1'b0, 11'($urandom_range(0, 2047)));
    for (int it = 0; it < 24; it++) begin
      int nd = $urandom_range(1, 3);
      for (int i = 0; i < nd; i++) begin opt = $urandom_range(0, 9); press(4'(opt)); end
      press(K_ENTER);
      if (opt == 0) begin
        check("rnd logout state", state_o, ST_IDLE);
        check("rnd logout exit", exit, 1);
        exp_bal = 0; exp_err = 0;
        do_login($urandom_range(1000, 4095), $urandom_range(0, 9), 1'b0, 11'($urandom_range(0, 2047)));
      end else if (opt < 3 || opt > 6) begin
        check("rnd menu reject state", state_o, ST_MENU);
        check("rnd menu reject pulse", disp_error, 1);
        @(negedge clk);
        check("rnd menu reject after", disp_error, exp_err);
      end else begin
        if (opt == 6) begin
          check("rnd DEST", state_o, ST_DEST);
          enter_field(4, 4095, ok, val);
          if (!ok) begin
            check("rnd dest reject", state_o, ST_DEST);
            check("rnd dest reject pulse", disp_error, 1);
            press(4'd7); press(K_ENTER); val = 7;
          end
          check("rnd dest value", destinationAcc, val);
        end
        if (opt != 3) begin
          check("rnd AMT", state_o, ST_AMT);
          enter_field(4, 2047, ok, val);
          if (!ok) begin
            check("rnd amt reject", state_o, ST_AMT);
            check("rnd amt reject pulse", disp_error, 1);
            press(4'd1); press(K_ENTER); val = 1;
          end
          check("rnd amount value", amount, val);
        end
        check("rnd ISSUE", state_o, ST_ISSUE);
        check("rnd menuOption", menuOption, opt);
        complete_req("rnd");
        err = ($urandom_range(0, 3) == 0);
        bal = 11'($urandom_range(0, 2047));
        respond_model(err, bal);
        check("rnd resp state", state_o, ST_MENU);
        check("rnd disp_error", disp_error, exp_err);
        check("rnd disp_balance", disp_balance, exp_bal);
        check("rnd amount cleared", amount, 0);
        check("rnd dest cleared", destinationAcc, 0);
      end
    end

    // Menu 0 logout: exit exactly one cycle
    press(4'd0); press(K_ENTER);
    check("menu0 exit", exit, 1);
    check("menu0 IDLE", state_o, ST_IDLE);
    @(negedge clk);
    check("menu0 exit one cycle", exit, 0);

    // Asynchronous reset in the middle of WAIT_RESP
    do_login(3210, 8, 1'b0, 11'd1999);
    press(4'd3); press(K_ENTER);
    complete_req("balance");
    #2 rst_n = 1'b0;
    #1;
    check("async rst state", state_o, 0);
    check("async rst accNumber", accNumber, 0);
    check("async rst pin", pin, 0);
    check("async rst menuOption", menuOption, 0);
    check("async rst disp_balance", disp_balance, 0);
    check("async rst disp_error", disp_error, 0);
    check("async rst req_valid", req_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
